core_regfile: RTL and testbench

//   Decode-side consumer of the writeback (wd_*) channel. Commits register writes into a
//   32x32 integer register file and serves the two decode read ports, with write-to-read bypass.

---
 rtl/core_regfile.sv | 89 ++++++++
 tb/tb_core_regfile.sv | 131 +++++++++++++
 2 files changed

// File: rtl/core_regfile.sv
// core_regfile: writeback-side register file (32x32, bypassed reads), one-entry CSR write buffer, instret counter
// Ports:
//   clk, rest                     clock, synchronous active-high reset
//   wd_valid / wd_ready           writeback handshake; transfer = wd_valid & wd_ready
//   wd_reg_data, wd_rd, wd_reg_write   integer register write request
//   wd_csr_data, wd_csr, wd_csr_write  CSR write request
//   rs1_addr/rs1_data, rs2_addr/rs2_data  combinational read ports
//   csr_valid/csr_ready, csr_addr, csr_wdata  buffered CSR write to the CSR unit
//   instret                       retired-instruction count
module core_regfile #(
    parameter bit RESET_REGS = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_reg_data,
    input  logic [4:0]  wd_rd,
    input  logic        wd_reg_write,
    input  logic [31:0] wd_csr_data,
    input  logic [11:0] wd_csr,
    input  logic        wd_csr_write,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    output logic        csr_valid,
    input  logic        csr_ready,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic [63:0] instret
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [31:0] regs [1:31];
    logic xfer, commit, reg_we, csr_we;
    assign csr_valid = (state == FULL);
    assign wd_ready  = ~csr_valid | csr_ready;
    assign xfer      = wd_valid & wd_ready;
    // reset wins over any same-cycle transfer, so nothing commits while rest is high
    assign commit    = xfer & ~rest;
    assign reg_we    = commit & wd_reg_write & (wd_rd != 5'd0);
    assign csr_we    = commit & wd_csr_write;
    always_ff @(posedge clk) begin
        if (rest)
            state <= EMPTY;
        else
            state <= state_nx;
    end
    // a new CSR write can only arrive when the buffer is empty or draining this cycle
    always_comb begin
        state_nx = state;
        state_nx = csr_we ? FULL : (csr_ready ? EMPTY : state);
    end
    always_ff @(posedge clk) begin
        if (rest) begin
            csr_addr  <= '0;
            csr_wdata <= '0;
        end else if (csr_we) begin
            csr_addr  <= wd_csr;
            csr_wdata <= wd_csr_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rest)
            instret <= '0;
        else if (commit)
            instret <= instret + 64'd1;
    end
    always_ff @(posedge clk) begin
        if (rest) begin
            if (RESET_REGS)
                for (int i = 1; i < 32; i++)
                    regs[i] <= '0;
        end else if (reg_we) begin
            regs[wd_rd] <= wd_reg_data;
        end
    end
    // during reset the ports already show the post-reset contents
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_data = (rs1_addr == 5'd0 || (rest && RESET_REGS)) ? 32'd0 :
                   (BYPASS && reg_we && wd_rd == rs1_addr) ? wd_reg_data : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0 || (rest && RESET_REGS)) ? 32'd0 :
                   (BYPASS && reg_we && wd_rd == rs2_addr) ? wd_reg_data : regs[rs2_addr];
    end
endmodule

// File: tb/tb_core_regfile.sv
// tb_core_regfile: randomized scoreboard bench for core_regfile against an array/queue reference model
module tb_core_regfile;
    logic        clk = 1'b0;
    logic        rest, wd_valid, wd_ready, wd_reg_write, wd_csr_write, csr_valid, csr_ready;
    logic [31:0] wd_reg_data, wd_csr_data, rs1_data, rs2_data, csr_wdata;
    logic [4:0]  wd_rd, rs1_addr, rs2_addr;
    logic [11:0] wd_csr, csr_addr;
    logic [63:0] instret;

    core_regfile #(.RESET_REGS(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rest(rest), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .wd_reg_data(wd_reg_data), .wd_rd(wd_rd), .wd_reg_write(wd_reg_write),
        .wd_csr_data(wd_csr_data), .wd_csr(wd_csr), .wd_csr_write(wd_csr_write),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .instret(instret)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    bit          started  = 1'b0;
    logic [31:0] mx [32];
    logic [63:0] minst;
    logic [43:0] csr_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit r, input bit x,
                                             input bit rw, input logic [4:0] rd, input logic [31:0] d);
        if (a == 0 || r) return 32'd0;
        if (x && rw && rd == a) return d;
        return mx[a];
    endfunction

    task automatic cyc(input bit v, input bit rw, input logic [4:0] rd, input logic [31:0] rdat,
                       input bit cw, input logic [11:0] ca, input logic [31:0] cd,
                       input logic [4:0] a1, input logic [4:0] a2, input bit cr, input bit r);
        bit exp_ready, x;
        wd_valid = v; wd_reg_write = rw; wd_rd = rd; wd_reg_data = rdat;
        wd_csr_write = cw; wd_csr = ca; wd_csr_data = cd;
        rs1_addr = a1; rs2_addr = a2; csr_ready = cr; rest = r;
        @(negedge clk);
        exp_ready = (csr_q.size() == 0) || cr;
        x = v && exp_ready && !r;
        if (started) begin
            chk("wd_ready", {63'd0, wd_ready}, {63'd0, exp_ready});
            chk("instret", instret, minst);
        end
        chk("rs1_data", {32'd0, rs1_data}, {32'd0, model_rd(a1, r, x, rw, rd, rdat)});
        chk("rs2_data", {32'd0, rs2_data}, {32'd0, model_rd(a2, r, x, rw, rd, rdat)});
        @(posedge clk);
        if (r) begin
            foreach (mx[i]) mx[i] = 32'd0;
            minst = 64'd0;
            csr_q.delete();
            started = 1'b1;
        end else if (x) begin
            minst++;
            if (rw && rd != 0) mx[rd] = rdat;
            if (cw) csr_q.push_back({ca, cd});
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input bit cr);
        cyc(0, 0, 0, 0, 0, 0, 0, a1, a2, cr, 0);
    endtask

    // CSR channel monitor: expected writes are popped as the CSR unit accepts them
    always @(negedge clk) begin
        if (started) begin
            chk("csr_valid", {63'd0, csr_valid}, {63'd0, csr_q.size() != 0});
            if (csr_valid && csr_q.size() != 0) begin
                chk("csr_addr", {52'd0, csr_addr}, {52'd0, csr_q[0][43:32]});
                chk("csr_wdata", {32'd0, csr_wdata}, {32'd0, csr_q[0][31:0]});
                if (csr_ready) void'(csr_q.pop_front());
            end
        end
    end

    initial begin
        foreach (mx[i]) mx[i] = 32'd0;
        minst = 64'd0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 3, 9, 1, 1);
        chk("reset_csr_addr", {52'd0, csr_addr}, 64'd0);
        chk("reset_csr_wdata", {32'd0, csr_wdata}, 64'd0);
        cyc(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 1, 0);
        idle(5, 0, 1);
        chk("x5_direct", {32'd0, rs1_data}, 64'hDEADBEEF);
        chk("instret_one", instret, 64'd1);
        cyc(1, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 1);
        cyc(1, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 7, 7, 1, 0);
        idle(7, 5, 1);
        cyc(1, 0, 0, 0, 1, 12'h300, 32'h8, 7, 5, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 9, 32'h99, 0, 0, 0, 9, 0, 0, 0);
        chk("held_addr", {52'd0, csr_addr}, 64'h300);
        idle(9, 0, 1);
        idle(9, 0, 1);
        cyc(1, 0, 0, 0, 1, 12'h341, 32'h1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 12'h342, 32'h2, 0, 0, 1, 0);
        idle(0, 0, 1);
        idle(0, 0, 1);
        cyc(1, 1, 3, 32'h33, 1, 12'h7C0, 32'hCAFE, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 3, 5, 0, 1);
        chk("rst_csr_valid", {63'd0, csr_valid}, 64'd0);
        chk("rst_csr_data", {32'd0, csr_wdata}, 64'd0);
        idle(3, 7, 0);
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rd, $urandom,
                $urandom_range(0, 2) == 0, 12'($urandom), $urandom,
                ($urandom_range(0, 3) == 0) ? rd : 5'($urandom),
                ($urandom_range(0, 3) == 0) ? rd : 5'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 3; i++) idle(0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
